zjh_scan_disp: RTL and testbench
================================

ZJH_SCAN_DISP -- requirements
Module: zjh_scan_disp

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits; legal range 2..8.
REQ-002 Parameter DIV, default 4, clock cycles per digit slot; legal range 2..65535.
REQ-003 Parameter SEG_ACTIVE_LOW, default 0; when 1, Seg and Dp are inverted at the output register.
REQ-004 Clock  in  1  single system clock; all state changes on its rising edge.
REQ-005 Aclr  in  1  reset, synchronous, active-high.
REQ-006 En  in  1  scan enable.
REQ-007 Load  in  1  capture strobe for Din/Dp_in.
REQ-008 Din  in  4*DIGITS  hex nibble per digit; nibble i = Din[4i+3:4i]; digit 0 is least significant.
REQ-009 Dp_in  in  DIGITS  decimal point per digit.
REQ-010 Blank_en  in  1  leading-zero blanking enable.
REQ-011 Y  out  DIGITS  digit select, active-low one-hot; Y[i] low = digit i lit.
REQ-012 Seg  out  7  segments {a,b,c,d,e,f,g} = Seg[6:0], active-high when SEG_ACTIVE_LOW=0.
REQ-013 Dp  out  1  decimal point of lit digit.
REQ-014 Tick  out  1  one-cycle pulse marking end of a digit slot.

Function
REQ-015 Shadow registers SHALL capture Din and Dp_in on any cycle with Load=1, independent of En; the displayed value changes at the first output update after capture.
REQ-016 Prescaler SHALL count 0..DIV-1 while En=1, wrap to 0, and hold while En=0.
REQ-017 Tick SHALL be a combinational decode asserted exactly when En=1 and prescaler=DIV-1.
REQ-018 Digit index SHALL advance on Tick, wrapping from DIGITS-1 to 0, and hold otherwise.
REQ-019 Dead time: in the cycle after Tick, Y SHALL be all-ones and Seg/Dp off; from the second cycle onward, the new digit is driven.
REQ-020 Y, Seg, and Dp SHALL be registered, reflecting index, dead flag, and shadow data of the previous cycle, i.e. 1-cycle latency.
REQ-021 Hex decode, given as abcdefg: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-022 Blanking: with Blank_en=1, digit i>0 SHALL have Seg off when nibble i and all higher nibbles are 0; digit 0 is never blanked; Dp is unaffected by blanking.
REQ-023 While En=0, Y SHALL be all-ones and Seg/Dp off from the next cycle; index and prescaler hold; on re-enable, the held digit resumes without dead time.
REQ-024 Load coincident with Tick: both take effect; the new digit shows the newly loaded nibble.
REQ-025 Off state SHALL mean Seg=0000000 and Dp=0 before the SEG_ACTIVE_LOW inversion.

Reset
REQ-026 Aclr=1 at a clock edge SHALL set prescaler=0, index=0, dead flag=0, shadow data=0, Y=all-ones, Seg/Dp=off, regardless of En or Load.
REQ-027 Aclr SHALL dominate Load and En in the same cycle.
REQ-028 Reset asserted mid-slot or during dead time SHALL abort the slot; after release with En=1, digit 0 is lit on the first output update.

Verification
REQ-029 DIGITS=4, DIV=4, reset, Load Din=16'h1234, En=1 -> Y=1110 with Seg=0110011 (4); Tick every 4 cycles; one all-ones cycle; then Y=1101 with Seg=1111001, then 1011 with 1101101, then 0111 with 0110000, then back to 1110 (wrap).
REQ-030 Din=16'h0070, Blank_en=1 -> digits 3,2 Seg=0000000; digit 1 Seg=1110000; digit 0 Seg=1111110; with Blank_en=0, digits 3,2 show 1111110.
REQ-031 Din=16'hABCD, Dp_in=4'b0101, SEG_ACTIVE_LOW=1 -> digit 0 Seg=1000010 and Dp=0; digit 1 Seg=0110001 and Dp=1; dead-time cycles show Seg=1111111 and Dp=1.
REQ-032 En dropped on the cycle after digit 2 appears for 10 cycles -> Y=1111 throughout, Tick=0; on re-enable, digit 2 resumes and its slot completes with its remaining prescaler count.
REQ-033 Load Din=16'h5555 on a Tick cycle at index 0 -> the next lit digit 1 shows 1011011; Aclr pulsed mid-slot -> outputs off the next cycle; after release with En=1, Y=1110 with Seg=1111110.

Source files
------------

// File: rtl/zjh_scan_disp.sv
// zjh_scan_disp: multiplexed seven-segment scanner with shadow data, dead time and leading-zero blanking
module zjh_scan_disp #(
  parameter int DIGITS = 4,
  parameter int DIV = 4,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  Clock,
  input  logic                  Aclr,
  input  logic                  En,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Din,
  input  logic [DIGITS-1:0]     Dp_in,
  input  logic                  Blank_en,
  output logic [DIGITS-1:0]     Y,
  output logic [6:0]            Seg,
  output logic                  Dp,
  output logic                  Tick
);
  localparam int IW = $clog2(DIGITS);
  localparam int PW = $clog2(DIV);
  localparam logic INV = SEG_ACTIVE_LOW != 0;
  localparam logic [6:0] HEX [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] din_q, din_d;
  logic [DIGITS-1:0]   dpi_q, dpi_d, y_q, y_d, zhi;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d, lit, blank;
  logic [3:0]          nib;
  // slot timing, shadow capture and next output pattern; the tick cycle itself yields the dark gap
  always_comb begin
    Tick = En && presc_q == PW'(DIV - 1);
    presc_d = !En ? presc_q : Tick ? '0 : presc_q + 1'b1;
    idx_d = !Tick ? idx_q : idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
    din_d = Load ? Din : din_q;
    dpi_d = Load ? Dp_in : dpi_q;
    zhi = '0;
    zhi[DIGITS-1] = din_q[4*DIGITS-1 -: 4] == 4'd0;
    for (int i = DIGITS - 2; i >= 0; i--) zhi[i] = zhi[i+1] && din_q[4*i +: 4] == 4'd0;
    nib = din_q[{idx_q, 2'b00} +: 4];
    blank = Blank_en && idx_q != '0 && zhi[idx_q];
    lit = En && !Tick;
    y_d = lit ? ~(DIGITS'(1) << idx_q) : '1;
    seg_d = (lit && !blank ? HEX[nib] : 7'd0) ^ {7{INV}};
    dp_d = (lit && dpi_q[idx_q]) ^ INV;
  end
  // state and output registers with synchronous clear
  always_ff @(posedge Clock) begin
    if (Aclr) begin
      presc_q <= '0;
      idx_q <= '0;
      din_q <= '0;
      dpi_q <= '0;
      y_q <= '1;
      seg_q <= {7{INV}};
      dp_q <= INV;
    end else begin
      presc_q <= presc_d;
      idx_q <= idx_d;
      din_q <= din_d;
      dpi_q <= dpi_d;
      y_q <= y_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
    end
  end
  assign Y = y_q;
  assign Seg = seg_q;
  assign Dp = dp_q;
endmodule

// File: tb/tb_zjh_scan_disp.sv
// tb_zjh_scan_disp: randomized and directed checks of zjh_scan_disp against a behavioural model
module tb_zjh_scan_disp;
  logic        Clock, Aclr, En, Load, Blank_en;
  logic [15:0] Din;
  logic [3:0]  Dp_in;
  logic [3:0]  Y, Y2;
  logic [6:0]  Seg, Seg2;
  logic        Dp, Dp2, Tick, Tick2;
  int errors = 0;
  int checks = 0;
  logic [6:0] hex_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [15:0] m_din = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_y = 4'hF;
  logic [6:0]  m_seg = '0;
  logic        m_dpo = 1'b0;
  logic        t_exp, t_obs, t2_obs;

  zjh_scan_disp #(.DIGITS(4), .DIV(4), .SEG_ACTIVE_LOW(0)) dut (
    .Clock(Clock), .Aclr(Aclr), .En(En), .Load(Load), .Din(Din), .Dp_in(Dp_in),
    .Blank_en(Blank_en), .Y(Y), .Seg(Seg), .Dp(Dp), .Tick(Tick));
  zjh_scan_disp #(.DIGITS(4), .DIV(4), .SEG_ACTIVE_LOW(1)) dut_n (
    .Clock(Clock), .Aclr(Aclr), .En(En), .Load(Load), .Din(Din), .Dp_in(Dp_in),
    .Blank_en(Blank_en), .Y(Y2), .Seg(Seg2), .Dp(Dp2), .Tick(Tick2));

  initial Clock = 0;
  always #5 Clock = ~Clock;

  task automatic step();
    logic bl;
    #1;
    t_exp = En && m_cnt == 3;
    t_obs = Tick;
    t2_obs = Tick2;
    @(posedge Clock);
    if (Aclr) begin
      m_cnt = 0; m_idx = 0; m_din = '0; m_dp = '0;
      m_y = 4'hF; m_seg = '0; m_dpo = 1'b0;
    end else begin
      bl = Blank_en && m_idx > 0 && (m_din >> (4 * m_idx)) == 16'd0;
      if (!En || t_exp) begin
        m_y = 4'hF; m_seg = '0; m_dpo = 1'b0;
      end else begin
        m_y = 4'hF & ~(4'd1 << m_idx);
        m_seg = bl ? 7'd0 : hex_tab[m_din[4*m_idx +: 4]];
        m_dpo = m_dp[m_idx];
      end
      if (En) m_cnt = t_exp ? 0 : m_cnt + 1;
      if (t_exp) m_idx = (m_idx + 1) % 4;
      if (Load) begin m_din = Din; m_dp = Dp_in; end
    end
    #1;
  endtask

  task automatic test_reset();
    Aclr = 1; En = 1; Load = 1; Din = 16'($urandom); Dp_in = 4'hF; Blank_en = 0;
    step();
    checks++;
    if ({Y, Seg, Dp} !== {4'hF, 7'd0, 1'b0}) begin
      errors++; $display("FAIL reset_hi: got y=%b seg=%b dp=%b want 1111 0000000 0", Y, Seg, Dp);
    end
    checks++;
    if ({Y2, Seg2, Dp2} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++; $display("FAIL reset_lo: got y=%b seg=%b dp=%b want 1111 1111111 1", Y2, Seg2, Dp2);
    end
    Aclr = 0; Load = 0; En = 0;
    step();
    checks++;
    if ({t_obs, Y, Seg, Dp} !== {t_exp, m_y, m_seg, m_dpo}) begin
      errors++; $display("FAIL reset_idle: got t=%b y=%b seg=%b dp=%b want t=%b y=%b seg=%b dp=%b", t_obs, Y, Seg, Dp, t_exp, m_y, m_seg, m_dpo);
    end
  endtask

  task automatic test_scan();
    int seen4 = 0;
    Din = 16'h1234; Dp_in = 4'h0; Load = 1; En = 1; Blank_en = 0;
    for (int i = 0; i < 26; i++) begin
      step();
      Load = 0;
      if (Y === 4'b1110 && Seg === 7'b0110011) seen4++;
      checks++;
      if ({t_obs, Y, Seg, Dp} !== {t_exp, m_y, m_seg, m_dpo}) begin
        errors++; $display("FAIL scan: got t=%b y=%b seg=%b dp=%b want t=%b y=%b seg=%b dp=%b", t_obs, Y, Seg, Dp, t_exp, m_y, m_seg, m_dpo);
      end
      checks++;
      if ({t2_obs, Y2, Seg2, Dp2} !== {t_exp, m_y, ~m_seg, ~m_dpo}) begin
        errors++; $display("FAIL scan_lo: got t=%b y=%b seg=%b dp=%b want t=%b y=%b seg=%b dp=%b", t2_obs, Y2, Seg2, Dp2, t_exp, m_y, ~m_seg, ~m_dpo);
      end
    end
    checks++;
    if (seen4 < 3) begin
      errors++; $display("FAIL scan_digit4: got %0d cycles of 1110/0110011 want >=3", seen4);
    end
  endtask

  task automatic test_blank();
    Din = 16'h0070; Load = 1; Blank_en = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      Load = 0;
      if (i == 19) Blank_en = 0;
      checks++;
      if ({t_obs, Y, Seg, Dp} !== {t_exp, m_y, m_seg, m_dpo}) begin
        errors++; $display("FAIL blank: got t=%b y=%b seg=%b dp=%b want t=%b y=%b seg=%b dp=%b", t_obs, Y, Seg, Dp, t_exp, m_y, m_seg, m_dpo);
      end
      checks++;
      if ({t2_obs, Y2, Seg2, Dp2} !== {t_exp, m_y, ~m_seg, ~m_dpo}) begin
        errors++; $display("FAIL blank_lo: got t=%b y=%b seg=%b dp=%b", t2_obs, Y2, Seg2, Dp2);
      end
    end
  endtask

  task automatic test_active_low();
    Din = 16'hABCD; Dp_in = 4'b0101; Load = 1; Blank_en = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      Load = 0;
      checks++;
      if ({t2_obs, Y2, Seg2, Dp2} !== {t_exp, m_y, ~m_seg, ~m_dpo}) begin
        errors++; $display("FAIL active_low: got t=%b y=%b seg=%b dp=%b want t=%b y=%b seg=%b dp=%b", t2_obs, Y2, Seg2, Dp2, t_exp, m_y, ~m_seg, ~m_dpo);
      end
    end
  endtask

  task automatic test_pause();
    int n = 0;
    while (m_y !== 4'b1011 && n < 40) begin step(); n++; end
    checks++;
    if (m_y !== 4'b1011 || Y !== 4'b1011) begin
      errors++; $display("FAIL pause_find: got y=%b want 1011 within 40 cycles", Y);
    end
    En = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({t_obs, Y, Seg, Dp} !== {1'b0, 4'hF, 7'd0, 1'b0}) begin
        errors++; $display("FAIL pause_off: got t=%b y=%b seg=%b dp=%b want 0 1111 0000000 0", t_obs, Y, Seg, Dp);
      end
    end
    En = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({t_obs, Y, Seg, Dp} !== {t_exp, m_y, m_seg, m_dpo}) begin
        errors++; $display("FAIL pause_resume: got t=%b y=%b seg=%b dp=%b want t=%b y=%b seg=%b dp=%b", t_obs, Y, Seg, Dp, t_exp, m_y, m_seg, m_dpo);
      end
    end
  endtask

  task automatic test_load_tick();
    int n = 0;
    while (!(m_cnt == 3 && m_idx == 0) && n < 40) begin step(); n++; end
    Din = 16'h5555; Load = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      Load = 0;
      checks++;
      if ({t_obs, Y, Seg, Dp} !== {t_exp, m_y, m_seg, m_dpo}) begin
        errors++; $display("FAIL load_tick: got t=%b y=%b seg=%b dp=%b want t=%b y=%b seg=%b dp=%b", t_obs, Y, Seg, Dp, t_exp, m_y, m_seg, m_dpo);
      end
    end
    Aclr = 1;
    step();
    checks++;
    if ({Y, Seg, Dp} !== {4'hF, 7'd0, 1'b0}) begin
      errors++; $display("FAIL midslot_reset: got y=%b seg=%b dp=%b want 1111 0000000 0", Y, Seg, Dp);
    end
    Aclr = 0;
    step();
    checks++;
    if ({Y, Seg} !== {4'b1110, 7'b1111110}) begin
      errors++; $display("FAIL reset_release: got y=%b seg=%b want 1110 1111110", Y, Seg);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      En = $urandom_range(0, 7) != 0;
      Load = $urandom_range(0, 5) == 0;
      Din = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
      Dp_in = 4'($urandom);
      Blank_en = 1'($urandom);
      Aclr = $urandom_range(0, 60) == 0;
      step();
      checks++;
      if ({t_obs, Y, Seg, Dp} !== {t_exp, m_y, m_seg, m_dpo}) begin
        errors++; $display("FAIL random: got t=%b y=%b seg=%b dp=%b want t=%b y=%b seg=%b dp=%b", t_obs, Y, Seg, Dp, t_exp, m_y, m_seg, m_dpo);
      end
      checks++;
      if ({t2_obs, Y2, Seg2, Dp2} !== {t_exp, m_y, ~m_seg, ~m_dpo}) begin
        errors++; $display("FAIL random_lo: got t=%b y=%b seg=%b dp=%b", t2_obs, Y2, Seg2, Dp2);
      end
    end
  endtask

  initial begin
    Aclr = 1; En = 0; Load = 0; Din = '0; Dp_in = '0; Blank_en = 0;
    test_reset();
    test_scan();
    test_blank();
    test_active_low();
    test_pause();
    test_load_tick();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
